// File: rtl/fp_align_pkg.sv
// Shared types and width helpers for the FP alignment stage.
// Float and lane-result layouts depend on the instance widths, so they are declared inside the modules.
package fp_align_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_FTOI = 3'd3,
    OP_ITOF = 3'd4,
    OP_CMP  = 3'd5
  } fp_op_t;

  function automatic int fp_bias(input int exp_width);
    return (1 << (exp_width - 1)) - 1;
  endfunction

  function automatic int fp_shift_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/fp_align_lane.sv
// One lane of the alignment stage: magnitude sort, multiply prep, ftoi/itof steering.
// Purely combinational; no flow control.
module fp_align_lane
  import fp_align_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 23,
  parameter int W         = 1 + EXP_WIDTH + SIG_WIDTH,
  parameter int SW        = fp_shift_width(W)
) (
  input  logic [2:0]           op,
  input  logic [W-1:0]         operand1,
  input  logic [W-1:0]         operand2,
  output logic [W-1:0]         sig_le,
  output logic [W-1:0]         sig_se,
  output logic [SW-1:0]        align_shift,
  output logic [SW-1:0]        ftoi_lshift,
  output logic [EXP_WIDTH-1:0] add_exp,
  output logic                 add_sign,
  output logic                 logical_sub,
  output logic [W-1:0]         mul_a,
  output logic [W-1:0]         mul_b,
  output logic [EXP_WIDTH-1:0] mul_exp,
  output logic                 mul_sign,
  output logic                 is_nan,
  output logic                 is_inf
);

  localparam int BIAS      = fp_bias(EXP_WIDTH);
  localparam int FTOI_ZERO = BIAS + SIG_WIDTH - W;
  localparam int FTOI_UNIT = BIAS + SIG_WIDTH;
  localparam int FTOI_OVF  = BIAS + W - 1;
  localparam int MAX_ALIGN = SIG_WIDTH + 4;

  typedef struct packed {
    logic                 sign;
    logic [EXP_WIDTH-1:0] exp;
    logic [SIG_WIDTH-1:0] sig;
  } fp_t;

  fp_t a, b;
  assign a = operand1;
  assign b = operand2;

  logic [W-1:0] full_a, full_b;
  assign full_a = W'({|a.exp, a.sig});
  assign full_b = W'({|b.exp, b.sig});

  logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  assign nan_a  = (&a.exp) & (|a.sig);
  assign nan_b  = (&b.exp) & (|b.sig);
  assign inf_a  = (&a.exp) & ~(|a.sig);
  assign inf_b  = (&b.exp) & ~(|b.sig);
  assign zero_a = ~(|a.exp) & ~(|a.sig);
  assign zero_b = ~(|b.exp) & ~(|b.sig);

  // Ties keep operand1 in the larger slot so the sign of +-0 follows operand1.
  logic sub, a_larger, addsub_lsub, add_nan, add_inf;
  assign sub         = (fp_op_t'(op) != OP_ADD);
  assign a_larger    = (a.exp > b.exp) || ((a.exp == b.exp) && (a.sig >= b.sig));
  assign addsub_lsub = a.sign ^ b.sign ^ sub;
  assign add_nan     = nan_a | nan_b | (inf_a & inf_b & addsub_lsub);
  assign add_inf     = (inf_a | inf_b) & ~add_nan;

  logic [EXP_WIDTH-1:0] exp_diff;
  logic [SW-1:0]        align_sat;
  assign exp_diff  = (a.exp > b.exp) ? a.exp - b.exp : b.exp - a.exp;
  assign align_sat = (int'(exp_diff) > MAX_ALIGN) ? SW'(MAX_ALIGN) : SW'(exp_diff);

  // Two guard bits: bit EXP_WIDTH is overflow, the top bit flags a negative (underflowed) sum.
  logic [EXP_WIDTH+1:0] mul_sum;
  logic                 mul_nan, mul_inf;
  assign mul_sum  = {2'b00, a.exp} + {2'b00, b.exp} - (EXP_WIDTH+2)'(BIAS);
  assign mul_nan  = nan_a | nan_b | (inf_a & zero_b) | (zero_a & inf_b);
  assign mul_inf  = mul_sum[EXP_WIDTH] & ~mul_sum[EXP_WIDTH+1];
  assign mul_a    = full_a;
  assign mul_b    = full_b;
  assign mul_exp  = mul_sum[EXP_WIDTH-1:0];
  assign mul_sign = a.sign ^ b.sign;

  int e2;
  assign e2 = int'(b.exp);

  always_comb begin
    sig_le      = a_larger ? full_a : full_b;
    sig_se      = a_larger ? full_b : full_a;
    align_shift = align_sat;
    ftoi_lshift = '0;
    add_exp     = a_larger ? a.exp : b.exp;
    add_sign    = a_larger ? a.sign : (b.sign ^ sub);
    logical_sub = addsub_lsub;
    is_nan      = add_nan;
    is_inf      = add_inf;
    case (fp_op_t'(op))
      OP_MUL: begin
        is_nan = mul_nan;
        is_inf = mul_inf;
      end
      OP_FTOI: begin
        sig_le      = '0;
        sig_se      = full_b;
        add_exp     = b.exp;
        add_sign    = b.sign;
        logical_sub = b.sign;
        is_inf      = 1'b0;
        is_nan      = nan_b | inf_b | (e2 >= FTOI_OVF);
        if (e2 < FTOI_ZERO) begin
          align_shift = SW'(W);
        end else if (e2 < FTOI_UNIT) begin
          align_shift = SW'(FTOI_UNIT - e2);
        end else begin
          align_shift = '0;
          ftoi_lshift = SW'(e2 - FTOI_UNIT);
        end
      end
      OP_ITOF: begin
        sig_le      = '0;
        sig_se      = operand2;
        align_shift = '0;
        add_exp     = EXP_WIDTH'(FTOI_UNIT);
        add_sign    = operand2[W-1];
        logical_sub = operand2[W-1];
        is_nan      = 1'b0;
        is_inf      = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fp_align_stage.sv
// FP pipeline stage 1: per-lane alignment with 1-cycle latency, one output register plus one skid entry.
// in_ready is registered (!skid_valid); flush kills matching beats in output, skid and input.
module fp_align_stage
  import fp_align_pkg::*;
#(
  parameter int NUM_LANES        = 16,
  parameter int EXP_WIDTH        = 8,
  parameter int SIG_WIDTH        = 23,
  parameter int THREAD_IDX_WIDTH = 2,
  localparam int W               = 1 + EXP_WIDTH + SIG_WIDTH,
  localparam int SW              = fp_shift_width(W)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [2:0]                     in_op,
  input  logic [NUM_LANES*W-1:0]         in_operand1,
  input  logic [NUM_LANES*W-1:0]         in_operand2,
  input  logic [NUM_LANES-1:0]           in_mask,
  input  logic [THREAD_IDX_WIDTH-1:0]    in_thread,
  input  logic                           flush_en,
  input  logic [THREAD_IDX_WIDTH-1:0]    flush_thread,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [2:0]                     out_op,
  output logic [NUM_LANES-1:0]           out_mask,
  output logic [THREAD_IDX_WIDTH-1:0]    out_thread,
  output logic [NUM_LANES*W-1:0]         out_sig_le,
  output logic [NUM_LANES*W-1:0]         out_sig_se,
  output logic [NUM_LANES*SW-1:0]        out_align_shift,
  output logic [NUM_LANES*SW-1:0]        out_ftoi_lshift,
  output logic [NUM_LANES*EXP_WIDTH-1:0] out_add_exp,
  output logic [NUM_LANES-1:0]           out_add_sign,
  output logic [NUM_LANES-1:0]           out_logical_sub,
  output logic [NUM_LANES*W-1:0]         out_mul_a,
  output logic [NUM_LANES*W-1:0]         out_mul_b,
  output logic [NUM_LANES*EXP_WIDTH-1:0] out_mul_exp,
  output logic [NUM_LANES-1:0]           out_mul_sign,
  output logic [NUM_LANES-1:0]           out_is_nan,
  output logic [NUM_LANES-1:0]           out_is_inf
);

  typedef struct packed {
    logic [W-1:0]         sig_le;
    logic [W-1:0]         sig_se;
    logic [SW-1:0]        align_shift;
    logic [SW-1:0]        ftoi_lshift;
    logic [EXP_WIDTH-1:0] add_exp;
    logic                 add_sign;
    logic                 logical_sub;
    logic [W-1:0]         mul_a;
    logic [W-1:0]         mul_b;
    logic [EXP_WIDTH-1:0] mul_exp;
    logic                 mul_sign;
    logic                 is_nan;
    logic                 is_inf;
  } lane_res_t;

  typedef struct packed {
    logic [2:0]                  op;
    logic [NUM_LANES-1:0]        mask;
    logic [THREAD_IDX_WIDTH-1:0] thread;
    lane_res_t [NUM_LANES-1:0]   lane;
  } beat_t;

  lane_res_t lane_res [NUM_LANES];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [W-1:0]         sig_le, sig_se, mul_a, mul_b;
    logic [SW-1:0]        align_shift, ftoi_lshift;
    logic [EXP_WIDTH-1:0] add_exp, mul_exp;
    logic                 add_sign, logical_sub, mul_sign, is_nan, is_inf;

    fp_align_lane #(
      .EXP_WIDTH (EXP_WIDTH),
      .SIG_WIDTH (SIG_WIDTH),
      .W         (W),
      .SW        (SW)
    ) u_lane (
      .op          (in_op),
      .operand1    (in_operand1[i*W +: W]),
      .operand2    (in_operand2[i*W +: W]),
      .sig_le      (sig_le),
      .sig_se      (sig_se),
      .align_shift (align_shift),
      .ftoi_lshift (ftoi_lshift),
      .add_exp     (add_exp),
      .add_sign    (add_sign),
      .logical_sub (logical_sub),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_exp     (mul_exp),
      .mul_sign    (mul_sign),
      .is_nan      (is_nan),
      .is_inf      (is_inf)
    );

    assign lane_res[i] = '{sig_le: sig_le, sig_se: sig_se, align_shift: align_shift,
                           ftoi_lshift: ftoi_lshift, add_exp: add_exp, add_sign: add_sign,
                           logical_sub: logical_sub, mul_a: mul_a, mul_b: mul_b,
                           mul_exp: mul_exp, mul_sign: mul_sign, is_nan: is_nan,
                           is_inf: is_inf};
  end

  beat_t in_beat;
  always_comb begin
    in_beat        = '0;
    in_beat.op     = in_op;
    in_beat.mask   = in_mask;
    in_beat.thread = in_thread;
    for (int i = 0; i < NUM_LANES; i++) begin
      in_beat.lane[i] = lane_res[i];
    end
  end

  beat_t out_q, skid_q;
  logic  out_valid_q, skid_valid, in_ready_q;

  // A killed output beat frees the register whether or not downstream was ready.
  logic out_kill, skid_kill, in_live, skid_live, out_free;
  assign out_kill  = flush_en && out_valid_q && (out_q.thread == flush_thread);
  assign skid_kill = flush_en && skid_valid && (skid_q.thread == flush_thread);
  assign in_live   = in_valid && in_ready_q && !(flush_en && (in_thread == flush_thread));
  assign skid_live = skid_valid && !skid_kill;
  assign out_free  = !out_valid_q || out_ready || out_kill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (out_free) begin
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
      if (skid_live) begin
        out_q       <= skid_q;
        out_valid_q <= 1'b1;
      end else if (in_live) begin
        out_q       <= in_beat;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_live) begin
      skid_q     <= in_beat;
      skid_valid <= 1'b1;
      in_ready_q <= 1'b0;
    end else begin
      skid_valid <= skid_live;
      in_ready_q <= !skid_live;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_op     = out_q.op;
  assign out_mask   = out_q.mask;
  assign out_thread = out_q.thread;

  always_comb begin
    out_sig_le      = '0;
    out_sig_se      = '0;
    out_align_shift = '0;
    out_ftoi_lshift = '0;
    out_add_exp     = '0;
    out_add_sign    = '0;
    out_logical_sub = '0;
    out_mul_a       = '0;
    out_mul_b       = '0;
    out_mul_exp     = '0;
    out_mul_sign    = '0;
    out_is_nan      = '0;
    out_is_inf      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      out_sig_le[i*W +: W]                   = out_q.lane[i].sig_le;
      out_sig_se[i*W +: W]                   = out_q.lane[i].sig_se;
      out_align_shift[i*SW +: SW]            = out_q.lane[i].align_shift;
      out_ftoi_lshift[i*SW +: SW]            = out_q.lane[i].ftoi_lshift;
      out_add_exp[i*EXP_WIDTH +: EXP_WIDTH]  = out_q.lane[i].add_exp;
      out_add_sign[i]                        = out_q.lane[i].add_sign;
      out_logical_sub[i]                     = out_q.lane[i].logical_sub;
      out_mul_a[i*W +: W]                    = out_q.lane[i].mul_a;
      out_mul_b[i*W +: W]                    = out_q.lane[i].mul_b;
      out_mul_exp[i*EXP_WIDTH +: EXP_WIDTH]  = out_q.lane[i].mul_exp;
      out_mul_sign[i]                        = out_q.lane[i].mul_sign;
      out_is_nan[i]                          = out_q.lane[i].is_nan;
      out_is_inf[i]                          = out_q.lane[i].is_inf;
    end
  end

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed-vector bench for fp_align_stage: float32 x16 lanes plus a half-precision x2 instance.
module tb_fp_align_stage;

  localparam int L = 16;

  logic clk, reset;
  logic in_valid, in_ready, flush_en, out_valid, out_ready;
  logic [2:0] in_op, out_op;
  logic [L*32-1:0] op1_v, op2_v;
  logic [L-1:0] in_mask, out_mask;
  logic [1:0] in_thread, flush_thread, out_thread;
  logic [L*32-1:0] out_sig_le, out_sig_se, out_mul_a, out_mul_b;
  logic [L*6-1:0] out_align_shift, out_ftoi_lshift;
  logic [L*8-1:0] out_add_exp, out_mul_exp;
  logic [L-1:0] out_add_sign, out_logical_sub, out_mul_sign, out_is_nan, out_is_inf;

  logic h_in_valid, h_in_ready, h_out_valid;
  logic [2:0] h_in_op, h_out_op;
  logic [31:0] h_op1, h_op2, h_sig_le, h_sig_se, h_mul_a, h_mul_b;
  logic [1:0] h_mask, h_out_mask, h_out_thread;
  logic [9:0] h_align, h_lshift, h_add_exp, h_mul_exp;
  logic [1:0] h_add_sign, h_lsub, h_mul_sign, h_nan, h_inf;

  int n_vec = 0;
  int n_err = 0;

  fp_align_stage u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_operand1(op1_v), .in_operand2(op2_v), .in_mask(in_mask), .in_thread(in_thread),
    .flush_en(flush_en), .flush_thread(flush_thread), .out_valid(out_valid),
    .out_ready(out_ready), .out_op(out_op), .out_mask(out_mask), .out_thread(out_thread),
    .out_sig_le(out_sig_le), .out_sig_se(out_sig_se), .out_align_shift(out_align_shift),
    .out_ftoi_lshift(out_ftoi_lshift), .out_add_exp(out_add_exp), .out_add_sign(out_add_sign),
    .out_logical_sub(out_logical_sub), .out_mul_a(out_mul_a), .out_mul_b(out_mul_b),
    .out_mul_exp(out_mul_exp), .out_mul_sign(out_mul_sign), .out_is_nan(out_is_nan),
    .out_is_inf(out_is_inf)
  );

  fp_align_stage #(.NUM_LANES(2), .EXP_WIDTH(5), .SIG_WIDTH(10), .THREAD_IDX_WIDTH(2)) u_half (
    .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready), .in_op(h_in_op),
    .in_operand1(h_op1), .in_operand2(h_op2), .in_mask(2'b11), .in_thread(2'd0),
    .flush_en(1'b0), .flush_thread(2'd0), .out_valid(h_out_valid),
    .out_ready(1'b1), .out_op(h_out_op), .out_mask(h_out_mask), .out_thread(h_out_thread),
    .out_sig_le(h_sig_le), .out_sig_se(h_sig_se), .out_align_shift(h_align),
    .out_ftoi_lshift(h_lshift), .out_add_exp(h_add_exp), .out_add_sign(h_add_sign),
    .out_logical_sub(h_lsub), .out_mul_a(h_mul_a), .out_mul_b(h_mul_b),
    .out_mul_exp(h_mul_exp), .out_mul_sign(h_mul_sign), .out_is_nan(h_nan),
    .out_is_inf(h_inf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] g32(input logic [L*32-1:0] v, input int l);
    return {32'd0, v[l*32 +: 32]};
  endfunction
  function automatic logic [63:0] g8(input logic [L*8-1:0] v, input int l);
    return {56'd0, v[l*8 +: 8]};
  endfunction
  function automatic logic [63:0] g6(input logic [L*6-1:0] v, input int l);
    return {58'd0, v[l*6 +: 6]};
  endfunction

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < L; i++) begin
      op1_v[i*32 +: 32] = a;
      op2_v[i*32 +: 32] = b;
    end
  endtask

  // One beat through an idle stage with out_ready high; returns at the sampling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] thr);
    @(negedge clk);
    in_op = op; set_ops(a, b); in_thread = thr; in_mask = 16'hA5C3 ^ {14'd0, thr};
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("beat_valid", out_valid, 1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush_en = 1'b0; flush_thread = 2'd0;
    in_op = 3'd0; in_thread = 2'd0; in_mask = '0; set_ops(32'd0, 32'd0);
    h_in_valid = 1'b0; h_in_op = 3'd0; h_op1 = '0; h_op2 = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sig_le", g32(out_sig_le, 0), 0);
    check("rst_half_in_ready", h_in_ready, 1);
    reset = 1'b0;

    issue(3'd0, 32'h3F800000, 32'h40000000, 2'd1);     // 1.0 + 2.0
    check("add12_sig_le", g32(out_sig_le, 0), 32'h800000);
    check("add12_sig_se", g32(out_sig_se, 0), 32'h800000);
    check("add12_shift", g6(out_align_shift, 0), 1);
    check("add12_exp", g8(out_add_exp, 0), 8'h80);
    check("add12_exp_l15", g8(out_add_exp, 15), 8'h80);
    check("add12_lsub", out_logical_sub[0], 0);
    check("add12_thread", out_thread, 1);
    check("add12_mask", out_mask, 16'hA5C2);
    check("add12_op", out_op, 0);

    issue(3'd0, 32'h3F800000, 32'h40400000, 2'd0);     // 1.0 + 3.0
    check("add13_sig_le", g32(out_sig_le, 0), 32'hC00000);
    check("add13_sig_se", g32(out_sig_se, 0), 32'h800000);
    check("add13_shift", g6(out_align_shift, 0), 1);

    issue(3'd1, 32'h3F800000, 32'h40000000, 2'd0);     // 1.0 - 2.0
    check("sub12_sign", out_add_sign[0], 1);
    check("sub12_lsub", out_logical_sub[0], 1);
    issue(3'd1, 32'h40000000, 32'h3F800000, 2'd0);     // 2.0 - 1.0
    check("sub21_sign", out_add_sign[3], 0);
    check("sub21_exp", g8(out_add_exp, 3), 8'h80);

    issue(3'd0, 32'h71800000, 32'h3F800000, 2'd0);     // 2^100 + 1.0
    check("add_sat_shift", g6(out_align_shift, 0), 27);
    check("add_sat_exp", g8(out_add_exp, 0), 8'hE3);

    issue(3'd0, 32'h80000000, 32'h00000000, 2'd0);     // -0 + +0
    check("zero_tie_sign", out_add_sign[0], 1);
    check("zero_tie_lsub", out_logical_sub[0], 1);

    issue(3'd1, 32'h7F800000, 32'h7F800000, 2'd0);     // inf - inf
    check("infsub_nan", out_is_nan[0], 1);
    check("infsub_inf", out_is_inf[0], 0);
    issue(3'd0, 32'h7F800000, 32'h7F800000, 2'd0);     // inf + inf
    check("infadd_nan", out_is_nan[0], 0);
    check("infadd_inf", out_is_inf[0], 1);
    issue(3'd5, 32'h7FC00000, 32'h3F800000, 2'd0);     // cmp NaN
    check("cmp_nan", out_is_nan[0], 1);

    issue(3'd3, 32'h0, 32'h40600000, 2'd0);            // ftoi 3.5
    check("ftoi35_rshift", g6(out_align_shift, 0), 22);
    check("ftoi35_lshift", g6(out_ftoi_lshift, 0), 0);
    check("ftoi35_lsub", out_logical_sub[0], 0);
    check("ftoi35_sig_se", g32(out_sig_se, 0), 32'hE00000);
    check("ftoi35_sig_le", g32(out_sig_le, 0), 0);
    check("ftoi35_nan", out_is_nan[0], 0);
    issue(3'd3, 32'h0, 32'h53800000, 2'd0);            // ftoi 2^40
    check("ftoi2p40_nan", out_is_nan[0], 1);
    check("ftoi2p40_lshift", g6(out_ftoi_lshift, 0), 17);
    issue(3'd3, 32'h0, 32'h4F000000, 2'd0);            // exp 158
    check("ftoi_e158_nan", out_is_nan[0], 1);
    issue(3'd3, 32'h0, 32'h4E800000, 2'd0);            // exp 157
    check("ftoi_e157_nan", out_is_nan[0], 0);
    check("ftoi_e157_lshift", g6(out_ftoi_lshift, 0), 7);
    check("ftoi_e157_rshift", g6(out_align_shift, 0), 0);
    issue(3'd3, 32'h0, 32'h32000000, 2'd0);            // exp 100
    check("ftoi_tiny_rshift", g6(out_align_shift, 0), 32);

    issue(3'd4, 32'h0, 32'hFFFFFFFB, 2'd0);            // itof -5
    check("itof_sig_se", g32(out_sig_se, 0), 32'hFFFFFFFB);
    check("itof_sig_le", g32(out_sig_le, 0), 0);
    check("itof_exp", g8(out_add_exp, 0), 150);
    check("itof_sign", out_add_sign[0], 1);
    check("itof_lsub", out_logical_sub[0], 1);
    check("itof_shift", g6(out_align_shift, 0), 0);

    issue(3'd2, 32'h7F800000, 32'h00000000, 2'd0);     // inf * 0
    check("mul_inf0_nan", out_is_nan[0], 1);
    issue(3'd2, 32'h00000000, 32'h7F800000, 2'd0);     // 0 * inf
    check("mul_0inf_nan", out_is_nan[0], 1);
    issue(3'd2, 32'h71800000, 32'h71800000, 2'd0);     // 2^100 * 2^100
    check("mul_big_inf", out_is_inf[0], 1);
    check("mul_big_exp", g8(out_mul_exp, 0), 8'h47);
    check("mul_big_nan", out_is_nan[0], 0);
    issue(3'd2, 32'h3FC00000, 32'hC0000000, 2'd0);     // 1.5 * -2.0
    check("mul_a", g32(out_mul_a, 0), 32'hC00000);
    check("mul_b", g32(out_mul_b, 0), 32'h800000);
    check("mul_exp", g8(out_mul_exp, 0), 8'h80);
    check("mul_sign", out_mul_sign[0], 1);
    issue(3'd2, 32'h00800000, 32'h00800000, 2'd0);     // underflowed sum
    check("mul_uf_inf", out_is_inf[0], 0);
    check("mul_uf_exp", g8(out_mul_exp, 0), 8'h83);

    // Backpressure: A on output, B in skid, C refused until space frees.
    @(negedge clk);
    out_ready = 1'b0; in_op = 3'd0; in_thread = 2'd0; in_valid = 1'b1;
    set_ops(32'h3F800000, 32'h3F800000);
    @(negedge clk);
    check("bp_rdy_c1", in_ready, 1);
    check("bp_vld_c1", out_valid, 1);
    set_ops(32'h40000000, 32'h40000000);
    @(negedge clk);
    check("bp_rdy_c2", in_ready, 0);
    check("bp_hold_a", g8(out_add_exp, 0), 127);
    set_ops(32'h40800000, 32'h40800000);
    @(negedge clk);
    check("bp_rdy_c3", in_ready, 0);
    check("bp_still_a", g8(out_add_exp, 0), 127);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_b_vld", out_valid, 1);
    check("bp_b", g8(out_add_exp, 0), 128);
    check("bp_rdy_back", in_ready, 1);
    @(negedge clk);
    check("bp_c", g8(out_add_exp, 0), 129);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_drain", out_valid, 0);

    // Flush thread 1: output holds t1, skid holds t2, incoming is t1.
    out_ready = 1'b0; in_valid = 1'b1; in_thread = 2'd1; set_ops(32'h3F800000, 32'h3F800000);
    @(negedge clk);
    in_thread = 2'd2; set_ops(32'h40000000, 32'h40000000);
    @(negedge clk);
    check("fl_skid_full", in_ready, 0);
    in_thread = 2'd1; set_ops(32'h40800000, 32'h40800000);
    flush_en = 1'b1; flush_thread = 2'd1;
    @(negedge clk);
    flush_en = 1'b0; in_valid = 1'b0;
    check("fl_vld", out_valid, 1);
    check("fl_thread", out_thread, 2);
    check("fl_exp", g8(out_add_exp, 0), 128);
    out_ready = 1'b1;
    @(negedge clk);
    check("fl_only_one", out_valid, 0);

    // Incoming beat of the flushed thread is dropped.
    in_valid = 1'b1; in_thread = 2'd1; flush_en = 1'b1; flush_thread = 2'd1;
    @(negedge clk);
    in_valid = 1'b0; flush_en = 1'b0;
    check("fl_in_drop", out_valid, 0);
    // Flush of another thread leaves the incoming beat alone.
    in_valid = 1'b1; in_thread = 2'd1; flush_en = 1'b1; flush_thread = 2'd3;
    @(negedge clk);
    in_valid = 1'b0; flush_en = 1'b0;
    check("fl_other_in", out_valid, 1);
    check("fl_other_thr", out_thread, 1);
    // Held output survives another thread's flush, then dies with a same-cycle transfer.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_thread = 2'd2;
    @(negedge clk);
    in_valid = 1'b0; flush_en = 1'b1; flush_thread = 2'd0;
    @(negedge clk);
    flush_en = 1'b0;
    check("fl_other_hold", out_valid, 1);
    flush_en = 1'b1; flush_thread = 2'd2; out_ready = 1'b1;
    @(negedge clk);
    flush_en = 1'b0;
    check("fl_xfer", out_valid, 0);

    // Reset mid-stream discards both held beats.
    out_ready = 1'b0; in_valid = 1'b1; in_thread = 2'd0;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("mr_full", in_ready, 0);
    reset = 1'b1;
    #1;
    check("mr_vld", out_valid, 0);
    check("mr_rdy", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mr_empty", out_valid, 0);
    out_ready = 1'b1;

    // Half precision: 1.0 + 2.0.
    h_in_op = 3'd0; h_op1 = {2{16'h3C00}}; h_op2 = {2{16'h4000}}; h_in_valid = 1'b1;
    @(negedge clk);
    h_in_valid = 1'b0;
    check("half_vld", h_out_valid, 1);
    check("half_exp", {59'd0, h_add_exp[4:0]}, 16);
    check("half_exp_l1", {59'd0, h_add_exp[9:5]}, 16);
    check("half_shift", {59'd0, h_align[4:0]}, 1);
    check("half_sig_le", {48'd0, h_sig_le[15:0]}, 16'h400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
